// File: rtl/cnn_core_pkg.sv
// cnn_core_pkg: shared activation encodings, width derivation and saturation helpers for the CNN core
package cnn_core_pkg;
  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_PASS  = 2'd3
  } act_e;
  localparam int LEAKY_SHIFT = 3;
  function automatic int acc_bw(input int i_bw, input int w_bw, input int k);
    return i_bw + w_bw + $clog2(k);
  endfunction
  function automatic int ab_bw(input int acc, input int b);
    return (acc > b ? acc : b) + 1;
  endfunction
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x, input int bw);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (bw - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (bw - 1));
    return x > hi ? hi : (x < lo ? lo : x);
  endfunction
endpackage

// File: rtl/cnn_dot_lane.sv
// cnn_dot_lane: one output-channel dot product; K multipliers, S1 product registers, adder tree.
//   clk, reset_n : clock, async active-low reset
//   en           : load S1 product registers (deasserted on stall)
//   fmap, w      : K-element window and weights, element k at [k*BW +: BW]
//   sum          : combinational sum of the registered products
module cnn_dot_lane #(
  parameter int K      = 18,
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int ACC_BW = 21
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic [K*I_F_BW-1:0]      fmap,
  input  logic [K*W_BW-1:0]        w,
  output logic signed [ACC_BW-1:0] sum
);
  localparam int P_BW = I_F_BW + W_BW;
  logic signed [P_BW-1:0] prod [K];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < K; k++) prod[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < K; k++)
        prod[k] <= P_BW'($signed(fmap[k*I_F_BW +: I_F_BW])) * P_BW'($signed(w[k*W_BW +: W_BW]));
    end
  end
  always_comb begin
    sum = '0;
    for (int k = 0; k < K; k++) sum = sum + ACC_BW'(prod[k]);
  end
endmodule

// File: rtl/cnn_core_pipe.sv
// cnn_core_pipe: CO-channel CNN core, 3-stage valid/ready pipeline with loadable weights/bias,
// activation and requantisation.
//   clk, reset_n            : clock, async active-low reset
//   i_soft_reset            : synchronous pipeline flush, config kept
//   i_w_we/addr/data        : weight write (index co*K+k), only while idle
//   i_b_we/addr/data        : bias write, only while idle
//   i_act_mode, i_shift     : activation and requant shift, captured with each beat
//   i_in_valid/o_in_ready   : input window handshake, i_in_fmap element k at [k*I_F_BW]
//   o_ot_valid/i_ot_ready   : output handshake, o_ot_fmap channel co at [co*O_F_BW]
//   o_busy                  : any stage holds a beat
//   o_cfg_err               : one-cycle pulse after a rejected config write
module cnn_core_pipe
  import cnn_core_pkg::*;
#(
  parameter int CO     = 4,
  parameter int CI     = 2,
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int B_BW   = 16,
  parameter int O_F_BW = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_soft_reset,
  input  logic                         i_w_we,
  input  logic [$clog2(CO*CI*KX*KY)-1:0] i_w_addr,
  input  logic [W_BW-1:0]              i_w_data,
  input  logic                         i_b_we,
  input  logic [$clog2(CO)-1:0]        i_b_addr,
  input  logic [B_BW-1:0]              i_b_data,
  input  logic [1:0]                   i_act_mode,
  input  logic [4:0]                   i_shift,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [CI*KX*KY*I_F_BW-1:0]   i_in_fmap,
  output logic                         o_ot_valid,
  input  logic                         i_ot_ready,
  output logic [CO*O_F_BW-1:0]         o_ot_fmap,
  output logic                         o_busy,
  output logic                         o_cfg_err
);
  localparam int K      = CI * KX * KY;
  localparam int ACC_BW = acc_bw(I_F_BW, W_BW, K);
  localparam int AB_BW  = ab_bw(ACC_BW, B_BW);
  logic signed [W_BW-1:0]   w_mem [CO*K];
  logic signed [B_BW-1:0]   b_mem [CO];
  logic signed [B_BW-1:0]   b1 [CO];
  logic signed [AB_BW-1:0]  s2 [CO];
  logic signed [ACC_BW-1:0] lane_sum [CO];
  logic [CO*O_F_BW-1:0]     q_flat;
  logic                     v1, v2, adv, w_bad, b_bad;
  logic [1:0]               mode1, mode2;
  logic [4:0]               sh1, sh2;
  assign adv        = ~(o_ot_valid & ~i_ot_ready);
  assign o_in_ready = adv;
  assign o_busy     = v1 | v2 | o_ot_valid;
  assign w_bad      = i_w_we & (o_busy | int'(i_w_addr) >= CO * K);
  assign b_bad      = i_b_we & (o_busy | int'(i_b_addr) >= CO);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CO * K; i++) w_mem[i] <= '0;
      for (int i = 0; i < CO; i++) b_mem[i] <= '0;
      o_cfg_err <= 1'b0;
    end else begin
      o_cfg_err <= ~i_soft_reset & (w_bad | b_bad);
      if (!i_soft_reset && i_w_we && !w_bad) w_mem[i_w_addr] <= i_w_data;
      if (!i_soft_reset && i_b_we && !b_bad) b_mem[i_b_addr] <= i_b_data;
    end
  end
  // Bias is captured at acceptance with the products so a same-cycle bias write cannot leak into the beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {v1, v2, o_ot_valid, mode1, mode2, sh1, sh2} <= '0;
      o_ot_fmap <= '0;
      for (int i = 0; i < CO; i++) begin
        b1[i] <= '0;
        s2[i] <= '0;
      end
    end else if (i_soft_reset) begin
      {v1, v2, o_ot_valid} <= '0;
      o_ot_fmap <= '0;
    end else if (adv) begin
      v1         <= i_in_valid;
      mode1      <= i_act_mode;
      sh1        <= i_shift;
      v2         <= v1;
      mode2      <= mode1;
      sh2        <= sh1;
      o_ot_valid <= v2;
      o_ot_fmap  <= q_flat;
      for (int i = 0; i < CO; i++) begin
        b1[i] <= b_mem[i];
        s2[i] <= AB_BW'(lane_sum[i]) + AB_BW'(b1[i]);
      end
    end
  end
  for (genvar c = 0; c < CO; c++) begin : g_lane
    logic [K*W_BW-1:0]  w_flat;
    logic signed [31:0] sx, r, a;
    always_comb begin
      w_flat = '0;
      for (int k = 0; k < K; k++) w_flat[k*W_BW +: W_BW] = w_mem[c*K + k];
    end
    cnn_dot_lane #(
      .K      (K),
      .I_F_BW (I_F_BW),
      .W_BW   (W_BW),
      .ACC_BW (ACC_BW)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (adv & ~i_soft_reset),
      .fmap    (i_in_fmap),
      .w       (w_flat),
      .sum     (lane_sum[c])
    );
    // Round half up before the arithmetic shift; activation acts on the rescaled value.
    always_comb begin
      sx = 32'(s2[c]);
      r  = sh2 == 5'd0 ? sx : (sx + (32'sd1 <<< (sh2 - 5'd1))) >>> sh2;
      a  = (r < 0 && mode2 == ACT_RELU) ? 32'sd0 :
           (r < 0 && mode2 == ACT_LEAKY) ? r >>> LEAKY_SHIFT : r;
    end
    assign q_flat[c*O_F_BW +: O_F_BW] = O_F_BW'(saturate(a, O_F_BW));
  end
endmodule

// File: tb/tb_cnn_core_pipe.sv
// tb_cnn_core_pipe: directed self-checking bench for cnn_core_pipe with hand-computed results
module tb_cnn_core_pipe;
  localparam int CO = 4, K = 18;
  logic          clk = 1'b0, reset_n = 1'b0, i_soft_reset = 1'b0;
  logic          i_w_we = 1'b0, i_b_we = 1'b0;
  logic [6:0]    i_w_addr = '0;
  logic [7:0]    i_w_data = '0;
  logic [1:0]    i_b_addr = '0;
  logic [15:0]   i_b_data = '0;
  logic [1:0]    i_act_mode = '0;
  logic [4:0]    i_shift = '0;
  logic          i_in_valid = 1'b0, i_ot_ready = 1'b1;
  logic [K*8-1:0] i_in_fmap = '0;
  logic          o_in_ready, o_ot_valid, o_busy, o_cfg_err;
  logic [CO*8-1:0] o_ot_fmap;
  int            n_chk = 0, n_fail = 0;

  cnn_core_pipe dut (
    .clk(clk), .reset_n(reset_n), .i_soft_reset(i_soft_reset),
    .i_w_we(i_w_we), .i_w_addr(i_w_addr), .i_w_data(i_w_data),
    .i_b_we(i_b_we), .i_b_addr(i_b_addr), .i_b_data(i_b_data),
    .i_act_mode(i_act_mode), .i_shift(i_shift),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_fmap(i_in_fmap),
    .o_ot_valid(o_ot_valid), .i_ot_ready(i_ot_ready), .o_ot_fmap(o_ot_fmap),
    .o_busy(o_busy), .o_cfg_err(o_cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [K*8-1:0] fill(input logic [7:0] v);
    return {K{v}};
  endfunction

  task automatic wr_w(input int a, input logic [7:0] d);
    i_w_we = 1'b1; i_w_addr = 7'(a); i_w_data = d;
    @(negedge clk);
    i_w_we = 1'b0;
  endtask

  task automatic wr_b(input int a, input logic [15:0] d);
    i_b_we = 1'b1; i_b_addr = 2'(a); i_b_data = d;
    @(negedge clk);
    i_b_we = 1'b0;
  endtask

  task automatic wr_all(input logic [7:0] w, input logic [15:0] b);
    for (int a = 0; a < CO * K; a++) wr_w(a, w);
    for (int a = 0; a < CO; a++) wr_b(a, b);
  endtask

  task automatic send(input logic [K*8-1:0] f, input logic [1:0] m, input logic [4:0] sh);
    i_in_fmap = f; i_act_mode = m; i_shift = sh; i_in_valid = 1'b1;
    @(negedge clk);
    i_in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!o_ot_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, o_ot_valid, 1);
    check(tag, o_ot_fmap, exp);
    @(negedge clk);
  endtask

  task automatic beat(input logic [K*8-1:0] f, input logic [1:0] m, input logic [4:0] sh,
                      input string tag, input logic [31:0] exp);
    send(f, m, sh);
    expect_out(tag, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int i, k;
    logic acc;
    logic [31:0] held;
    logic [7:0] e8;
    repeat (2) @(negedge clk);
    check("rst_valid", o_ot_valid, 0);
    check("rst_fmap", o_ot_fmap, 0);
    check("rst_err", o_cfg_err, 0);
    check("rst_busy", o_busy, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", o_in_ready, 1);

    // basic function and latency
    wr_all(8'd1, 16'd4);
    send(fill(8'd2), 2'd1, 5'd0);
    check("lat1", o_ot_valid, 0);
    @(negedge clk);
    check("lat2", o_ot_valid, 0);
    @(negedge clk);
    check("lat3", o_ot_valid, 1);
    expect_out("relu40", {4{8'd40}});

    // per-lane weights (c+1) and biases (10c)
    for (int c = 0; c < CO; c++) begin
      for (int j = 0; j < K; j++) wr_w(c * K + j, 8'(c + 1));
      wr_b(c, 16'(10 * c));
    end
    beat(fill(8'd1), 2'd0, 5'd0, "lanes", {8'd102, 8'd74, 8'd46, 8'd18});

    // negative sums and activations
    wr_all(8'hFF, 16'd0);
    beat(fill(8'd10), 2'd1, 5'd0, "neg_relu", {4{8'd0}});
    beat(fill(8'd10), 2'd0, 5'd0, "neg_none", {4{8'h80}});
    beat(fill(8'd10), 2'd2, 5'd0, "neg_leaky", {4{8'hE9}});
    beat(fill(8'd10), 2'd3, 5'd0, "neg_mode3", {4{8'h80}});

    // requantisation and saturation
    wr_all(8'd1, 16'd2);
    beat(fill(8'd2), 2'd1, 5'd2, "shift2", {4{8'd10}});
    beat(fill(8'd11), 2'd1, 5'd0, "sat_hi", {4{8'd127}});
    i_in_fmap = fill(8'd2); i_act_mode = 2'd0; i_shift = 5'd2; i_in_valid = 1'b1;
    @(negedge clk);
    i_shift = 5'd0;
    @(negedge clk);
    i_in_valid = 1'b0;
    i_shift = 5'd3;
    expect_out("carry_a", {4{8'd10}});
    expect_out("carry_b", {4{8'd38}});
    for (int a = 0; a < CO; a++) wr_b(a, 16'd0);
    beat({{(K-1){8'h00}}, 8'hFA}, 2'd0, 5'd1, "round_neg", {4{8'hFD}});

    // back-to-back stream with a 5-cycle downstream stall
    i = 0; k = 0; held = '0;
    for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
      i_ot_ready = !(cyc >= 5 && cyc < 10);
      #1;
      if (o_ot_valid && !i_ot_ready) begin
        check("stall_ready", o_in_ready, 0);
        if (cyc > 5) check("stall_hold", o_ot_fmap, held);
      end
      if (o_ot_valid) held = o_ot_fmap;
      if (o_ot_valid && i_ot_ready) begin
        e8 = (18 * (k + 1) > 127) ? 8'd127 : 8'(18 * (k + 1));
        check($sformatf("stream%0d", k), o_ot_fmap, {4{e8}});
        k++;
      end
      i_in_valid = (i < 8);
      i_in_fmap = fill(8'(i + 1));
      i_act_mode = 2'd0; i_shift = 5'd0;
      acc = i_in_valid && o_in_ready;
      @(negedge clk);
      if (acc) i++;
    end
    i_in_valid = 1'b0; i_ot_ready = 1'b1;
    check("stream_cnt", k, 8);
    repeat (4) @(negedge clk);

    // config write in the same cycle as a beat: the beat keeps old values
    i_in_fmap = fill(8'd1); i_act_mode = 2'd0; i_shift = 5'd0; i_in_valid = 1'b1;
    i_w_we = 1'b1; i_w_addr = 7'd0; i_w_data = 8'd5;
    i_b_we = 1'b1; i_b_addr = 2'd0; i_b_data = 16'd100;
    @(negedge clk);
    i_in_valid = 1'b0; i_w_we = 1'b0; i_b_we = 1'b0;
    check("idle_wr_err", o_cfg_err, 0);
    expect_out("old_cfg", {4{8'd18}});
    beat(fill(8'd1), 2'd0, 5'd0, "new_cfg", {8'd18, 8'd18, 8'd18, 8'd122});

    // write while busy is rejected
    send(fill(8'd1), 2'd0, 5'd0);
    wr_w(1, 8'd50);
    check("busy_err", o_cfg_err, 1);
    @(negedge clk);
    check("busy_err_pulse", o_cfg_err, 0);
    expect_out("busy_beat", {8'd18, 8'd18, 8'd18, 8'd122});
    beat(fill(8'd1), 2'd0, 5'd0, "w_kept", {8'd18, 8'd18, 8'd18, 8'd122});
    wr_w(CO * K, 8'd1);
    check("oor_err", o_cfg_err, 1);
    @(negedge clk);
    check("oor_err_pulse", o_cfg_err, 0);
    wr_w(0, 8'd1);
    check("ok_wr_err", o_cfg_err, 0);

    // soft reset with 3 beats in flight
    i_in_fmap = fill(8'd1); i_in_valid = 1'b1;
    repeat (3) @(negedge clk);
    i_in_valid = 1'b0;
    check("sr_busy_pre", o_busy, 1);
    i_soft_reset = 1'b1;
    i_w_we = 1'b1; i_w_addr = 7'd0; i_w_data = 8'd9;
    @(negedge clk);
    i_soft_reset = 1'b0; i_w_we = 1'b0;
    check("sr_valid", o_ot_valid, 0);
    check("sr_busy", o_busy, 0);
    check("sr_fmap", o_ot_fmap, 0);
    check("sr_err", o_cfg_err, 0);
    beat(fill(8'd1), 2'd0, 5'd0, "sr_retained", {8'd18, 8'd18, 8'd18, 8'd118});

    // asynchronous reset mid-operation
    i_ot_ready = 1'b0;
    send(fill(8'd1), 2'd0, 5'd0);
    repeat (2) @(negedge clk);
    check("ar_pre_valid", o_ot_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_valid", o_ot_valid, 0);
    check("ar_fmap", o_ot_fmap, 0);
    check("ar_busy", o_busy, 0);
    @(negedge clk);
    reset_n = 1'b1; i_ot_ready = 1'b1;
    @(negedge clk);
    beat(fill(8'd2), 2'd0, 5'd0, "ar_w_cleared", {4{8'd0}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
